// File: rtl/ldl_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
// No logic state; pure typedefs and combinational helper function.
// Backpressure: n/a.
package ldl_pkg;

   typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;

   // Widest request vector the lowest-set-bit helper can scan.
   localparam int LDL_MAXW = 64;

   function automatic int unsigned ldl_lsb_idx(input logic [LDL_MAXW-1:0] v);
      ldl_lsb_idx = 0;
      for (int i = LDL_MAXW - 1; i >= 0; i--) begin
         if (v[i]) ldl_lsb_idx = i;
      end
   endfunction

endpackage

// File: rtl/ldl_rr_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
// Latency: none (wires only).
// Backpressure: out_ready from the consumer holds the presented grant.
interface ldl_rr_arbiter_if #(parameter int WIDTH = 8);

   localparam int IDXW = $clog2(WIDTH);

   logic [WIDTH-1:0] req;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] grant;
   logic [IDXW-1:0]  grant_idx;

   modport master (
      input  req,
      input  out_ready,
      output out_valid,
      output grant,
      output grant_idx
   );

   modport slave (
      output req,
      output out_ready,
      input  out_valid,
      input  grant,
      input  grant_idx
   );

endinterface

// File: rtl/ldl_rr_arbiter_ring_shift_right.sv
// Rotates x right by sel positions: y[i] = x[(i + sel) mod WIDTH].
// Latency: combinational.
// Backpressure: n/a.
module LDL_ring_shift_right #(
   parameter int WIDTH = 8
) (
   input  logic [$clog2(WIDTH)-1:0] sel,
   input  logic [WIDTH-1:0]         x,
   output logic [WIDTH-1:0]         y
);

   // Doubling the vector makes the wrap fall out of a plain shift for any WIDTH.
   assign y = WIDTH'({x, x} >> sel);

endmodule

// File: rtl/ldl_rr_arbiter.sv
// Registered round-robin arbiter over WIDTH level requests (WIDTH <= LDL_MAXW).
// Latency: request in IDLE -> out_valid one cycle later; one grant per cycle when ready.
// Backpressure: out_ready low freezes grant, index and pointer; request changes ignored.
module ldl_rr_arbiter
   import ldl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   ldl_rr_arbiter_if.master  arb
);

   localparam int              IDXW     = $clog2(WIDTH);
   localparam logic [IDXW:0]   LP_WIDTH = (IDXW+1)'(WIDTH);
   localparam logic [IDXW-1:0] LP_LAST  = IDXW'(WIDTH - 1);

   arb_state_e       r_state;
   logic             r_vld;
   logic [WIDTH-1:0] r_grant;
   logic [IDXW-1:0]  r_idx;
   logic [IDXW-1:0]  r_ptr;

   logic [WIDTH-1:0] w_req_m;
   logic [WIDTH-1:0] w_rot;
   logic [WIDTH-1:0] w_gnt;
   logic [IDXW-1:0]  w_k;
   logic [IDXW-1:0]  w_idx;
   logic [IDXW-1:0]  w_ptr_nxt;
   logic [IDXW:0]    w_sum;
   logic             w_any;

   // The current winner still holds req during its accept cycle; mask it out.
   assign w_req_m = (r_state == ARB_HOLD) ? (arb.req & ~r_grant) : arb.req;

   LDL_ring_shift_right #(.WIDTH(WIDTH)) u_rot (
      .sel (r_ptr),
      .x   (w_req_m),
      .y   (w_rot)
   );

   assign w_any     = |w_req_m;
   assign w_k       = IDXW'(ldl_lsb_idx(LDL_MAXW'(w_rot)));
   assign w_sum     = {1'b0, r_ptr} + {1'b0, w_k};
   assign w_idx     = (w_sum >= LP_WIDTH) ? IDXW'(w_sum - LP_WIDTH) : w_sum[IDXW-1:0];
   assign w_gnt     = WIDTH'(1) << w_idx;
   assign w_ptr_nxt = (w_idx == LP_LAST) ? '0 : w_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ARB_IDLE;
         r_vld   <= 1'b0;
         r_grant <= '0;
         r_idx   <= '0;
         r_ptr   <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_any) begin
                  r_state <= ARB_HOLD;
                  r_vld   <= 1'b1;
                  r_grant <= w_gnt;
                  r_idx   <= w_idx;
                  r_ptr   <= w_ptr_nxt;
               end
            end
            ARB_HOLD: begin
               if (arb.out_ready) begin
                  if (w_any) begin
                     r_grant <= w_gnt;
                     r_idx   <= w_idx;
                     r_ptr   <= w_ptr_nxt;
                  end else begin
                     r_state <= ARB_IDLE;
                     r_vld   <= 1'b0;
                     r_grant <= '0;
                     r_idx   <= '0;
                  end
               end
            end
            default: begin
               r_state <= ARB_IDLE;
               r_vld   <= 1'b0;
               r_grant <= '0;
               r_idx   <= '0;
            end
         endcase
      end
   end

   assign arb.out_valid = r_vld;
   assign arb.grant     = r_grant;
   assign arb.grant_idx = r_idx;

endmodule
